// File: rtl/seg_pkg.sv
// Shared constants and frame payload for the seven-segment frame decoder.
package seg_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned DATA_W = NIB_W * DIGITS;

    // All cathodes off (active-low).
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Hex digit to {g,f,e,d,c,b,a}, active-low.
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // One displayable frame: four nibbles plus four decimal points, leftmost first.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DIGITS-1:0] dp;
    } frame_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] hex,
    output logic [SEG_W-1:0] seg_c
);

    // Table lookup; the table lives in the package so the top can share constants.
    assign seg_c = HEX_SEG[hex];

endmodule

// File: rtl/seg_frame_decoder.sv
// Four-digit seven-segment decoder with frame-synchronous display update.
// A new value is staged on load and only becomes visible at the next frame
// boundary (synced digit select wrapping 3 -> 0), so a frame never mixes
// old and new digits.
// Optional: define SEG_FRAME_DECODER_BLINK_EN to add per-digit blinking
// (blink_mask port plus a free-running counter); without it nothing blinks.
module seg_frame_decoder
    import seg_pkg::*;
#(
    parameter int unsigned BLANK_LZ  = 1,
    parameter int unsigned BLINK_DIV = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        choice,
    input  logic              load,
    input  logic [15:0]       data_in,
    input  logic [3:0]        dp_in,
`ifdef SEG_FRAME_DECODER_BLINK_EN
    input  logic [3:0]        blink_mask,
`endif
    output logic [SEG_W-1:0]  seg,
    output logic              dp,
    output logic              pending
);

    logic [1:0]       choice_s1;
    logic [1:0]       choice_s2;
    logic [1:0]       choice_prev;
    logic [1:0]       bit_idx_c;
    logic             boundary_c;
    frame_t           in_frame_c;
    frame_t           stage_q;
    frame_t           display_q;
    frame_t           display_nxt_c;
    logic [NIB_W-1:0] nibble_c;
    logic             lz_c;
    logic             blank_c;
    logic             blink_c;
    logic             dp_bit_c;
    logic [SEG_W-1:0] hex_seg_c;

    assign in_frame_c = {data_in, dp_in};
    assign boundary_c = (choice_prev == 2'd3) && (choice_s2 == 2'd0);
    // Digit 0 is the leftmost, which sits at bit 3 of dp/blink vectors.
    assign bit_idx_c  = ~choice_s2;

    // Synchronisers, boundary history, stage/display registers and pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            choice_s1   <= 2'd0;
            choice_s2   <= 2'd0;
            choice_prev <= 2'd0;
            stage_q     <= '0;
            display_q   <= '0;
            pending     <= 1'b0;
        end else begin
            choice_s1   <= choice;
            choice_s2   <= choice_s1;
            choice_prev <= choice_s2;
            display_q   <= display_nxt_c;
            if (load) begin
                stage_q <= in_frame_c;
            end
            if (boundary_c) begin
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Display contents as of this edge: a load on the boundary bypasses the stage.
    always_comb begin
        display_nxt_c = display_q;
        if (boundary_c) begin
            if (load) begin
                display_nxt_c = in_frame_c;
            end else if (pending) begin
                display_nxt_c = stage_q;
            end
        end
    end

    // Select the nibble for the active digit and flag leading zeros.
    always_comb begin
        nibble_c = display_nxt_c.data[3:0];
        lz_c     = 1'b0;
        case (choice_s2)
            2'd0: begin
                nibble_c = display_nxt_c.data[15:12];
                lz_c     = (display_nxt_c.data[15:12] == 4'd0);
            end
            2'd1: begin
                nibble_c = display_nxt_c.data[11:8];
                lz_c     = (display_nxt_c.data[15:8] == 8'd0);
            end
            2'd2: begin
                nibble_c = display_nxt_c.data[7:4];
                lz_c     = (display_nxt_c.data[15:4] == 12'd0);
            end
            default: begin
                nibble_c = display_nxt_c.data[3:0];
                lz_c     = 1'b0;
            end
        endcase
    end

    assign blank_c  = (BLANK_LZ != 0) && lz_c;
    assign dp_bit_c = display_nxt_c.dp[bit_idx_c];

`ifdef SEG_FRAME_DECODER_BLINK_EN
    logic [31:0] blink_cnt;

    // Free-running blink time base.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end

    assign blink_c = blink_mask[bit_idx_c] & blink_cnt[5'(BLINK_DIV)];
`else
    // No counter in this build: the blink phase reads as permanently off.
    localparam logic [31:0] BLINK_CNT_IDLE = '0;
    assign blink_c = BLINK_CNT_IDLE[5'(BLINK_DIV)];
`endif

    hex_to_seg u_hex_to_seg (
        .hex   (nibble_c),
        .seg_c (hex_seg_c)
    );

    // Output register; blanking keeps dp, blinking hides the whole digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            seg <= (blank_c || blink_c) ? SEG_BLANK : hex_seg_c;
            dp  <= blink_c ? 1'b1 : ~dp_bit_c;
        end
    end

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Self-checking bench for seg_frame_decoder (default parameters).
module tb_seg_frame_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  choice;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic        pending;
`ifdef SEG_FRAME_DECODER_BLINK_EN
    logic [3:0]  blink_mask = 4'b0000;
`endif

    always #5 clk = ~clk;

    seg_frame_decoder #(.BLANK_LZ(1), .BLINK_DIV(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .choice     (choice),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
`ifdef SEG_FRAME_DECODER_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .seg        (seg),
        .dp         (dp),
        .pending    (pending)
    );

    int checks = 0;
    int errors = 0;

    // Reference segment patterns, active-low {g,f,e,d,c,b,a}.
    logic [6:0] hex_ref [16];

    // Behavioural model: choice delay line plus staged/displayed frames.
    logic [1:0]  hist [3];
    logic [15:0] m_stage_d, m_disp_d;
    logic [3:0]  m_stage_p, m_disp_p;
    logic        m_pend;
    logic [6:0]  m_seg;
    logic        m_dp;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dpv;
        logic [27:0] exp_seg;   // digit 0 in the top 7 bits
        logic [3:0]  exp_dp;    // digit 0 at bit 3, active-low
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic [1:0] c, input logic ld, input logic [15:0] d,
                                input logic [3:0] p, input logic r);
        logic [1:0] eff;
        logic [1:0] prev;
        int         pos;
        int         upper;
        if (r) begin
            for (int i = 0; i < 3; i++) hist[i] = 2'd0;
            m_stage_d = '0; m_stage_p = '0;
            m_disp_d  = '0; m_disp_p  = '0;
            m_pend    = 1'b0;
            m_seg     = 7'h7F;
            m_dp      = 1'b1;
        end else begin
            // The digit in use now was applied two clocks ago.
            eff  = hist[1];
            prev = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = c;
            if (prev == 2'd3 && eff == 2'd0) begin
                if (ld) begin
                    m_disp_d = d; m_disp_p = p;
                end else if (m_pend) begin
                    m_disp_d = m_stage_d; m_disp_p = m_stage_p;
                end
                m_pend = 1'b0;
            end else if (ld) begin
                m_stage_d = d; m_stage_p = p;
                m_pend    = 1'b1;
            end
            pos   = 3 - int'(eff);
            upper = int'(m_disp_d) >> (4 * pos);
            if (eff != 2'd3 && upper == 0) m_seg = 7'h7F;
            else                           m_seg = hex_ref[upper & 15];
            m_dp = ~m_disp_p[pos];
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic [1:0] c, input logic ld, input logic [15:0] d,
                        input logic [3:0] p, input logic r);
        choice  = c;
        load    = ld;
        data_in = d;
        dp_in   = p;
        rst     = r;
        @(posedge clk);
        model_update(c, ld, d, p, r);
        #1;
        chk("model_seg", 16'(seg), 16'(m_seg));
        chk("model_dp", 16'(dp), 16'(m_dp));
        chk("model_pending", 16'(pending), 16'(m_pend));
    endtask

    task automatic hold(input logic [1:0] c, input int n);
        for (int i = 0; i < n; i++) step(c, 1'b0, 16'h0000, 4'h0, 1'b0);
    endtask

    // Load a vector with the select parked on digit 3, then walk one frame.
    task automatic run_vec(input vec_t v);
        step(2'd3, 1'b1, v.data, v.dpv, 1'b0);
        chk("vec_pending_set", 16'(pending), 16'd1);
        hold(2'd3, 4);
        chk("vec_pending_held", 16'(pending), 16'd1);
        for (int d = 0; d < 4; d++) begin
            hold(2'(d), 4);
            chk("vec_seg", 16'(seg), 16'(v.exp_seg[27 - 7 * d -: 7]));
            chk("vec_dp", 16'(dp), 16'(v.exp_dp[3 - d]));
        end
        chk("vec_pending_clr", 16'(pending), 16'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       saw_old;
        logic [1:0] cur;
        logic [15:0] mask;

        hex_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        vecs[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'h00A5, 4'b0000, {7'h7F, 7'h7F, 7'h08, 7'h12}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b1010, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0101};
        vecs[3] = '{16'h8F0C, 4'b0001, {7'h00, 7'h0E, 7'h40, 7'h46}, 4'b1110};
        vecs[4] = '{16'h0B0D, 4'b0100, {7'h7F, 7'h03, 7'h40, 7'h21}, 4'b1011};
        vecs[5] = '{16'h6709, 4'b0000, {7'h02, 7'h78, 7'h40, 7'h10}, 4'b1111};
        vecs[6] = '{16'hE000, 4'b1000, {7'h06, 7'h40, 7'h40, 7'h40}, 4'b0111};

        rst = 1'b1; choice = 2'd0; load = 1'b0; data_in = '0; dp_in = '0;

        // Reset with a load attempt that must be ignored.
        step(2'd0, 1'b0, 16'h0000, 4'h0, 1'b1);
        step(2'd0, 1'b1, 16'h9999, 4'hF, 1'b1);
        chk("rst_seg", 16'(seg), 16'h007F);
        chk("rst_dp", 16'(dp), 16'd1);
        chk("rst_pending", 16'(pending), 16'd0);

        // After reset: digit 3 shows 0, digit 0 is blanked.
        hold(2'd0, 4);
        chk("post_rst_d0_blank", 16'(seg), 16'h007F);
        hold(2'd3, 4);
        chk("post_rst_d3_zero", 16'(seg), 16'h0040);
        chk("post_rst_pending", 16'(pending), 16'd0);

        // Table vectors.
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Newest load wins; the earlier staged value never shows.
        step(2'd3, 1'b1, 16'h1111, 4'h0, 1'b0);
        step(2'd3, 1'b1, 16'h2222, 4'h0, 1'b0);
        hold(2'd3, 2);
        saw_old = 1'b0;
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 4; k++) begin
                step(2'(d), 1'b0, 16'h0, 4'h0, 1'b0);
                if (seg == 7'h79) saw_old = 1'b1;
            end
            chk("overwrite_seg", 16'(seg), 16'h0024);
        end
        chk("overwrite_never_old", 16'(saw_old), 16'd0);

        // Load on the boundary cycle goes straight to display.
        step(2'd3, 1'b1, 16'h1234, 4'h0, 1'b0);
        step(2'd0, 1'b0, 16'h0000, 4'h0, 1'b0);
        step(2'd0, 1'b0, 16'h0000, 4'h0, 1'b0);
        step(2'd0, 1'b1, 16'hFFFF, 4'h0, 1'b0);
        chk("bypass_seg_d0", 16'(seg), 16'h000E);
        chk("bypass_pending", 16'(pending), 16'd0);
        for (int d = 1; d < 4; d++) begin
            hold(2'(d), 4);
            chk("bypass_seg", 16'(seg), 16'h000E);
            chk("bypass_pending_hold", 16'(pending), 16'd0);
        end

        // Reset mid-frame with a value pending.
        step(2'd3, 1'b1, 16'h5555, 4'hF, 1'b0);
        chk("midrst_pending_set", 16'(pending), 16'd1);
        hold(2'd1, 2);
        for (int k = 0; k < 3; k++) begin
            step(2'd1, 1'b1, 16'h7777, 4'hF, 1'b1);
            chk("midrst_seg", 16'(seg), 16'h007F);
            chk("midrst_dp", 16'(dp), 16'd1);
            chk("midrst_pending", 16'(pending), 16'd0);
        end
        hold(2'd3, 4);
        chk("midrst_d3_zero", 16'(seg), 16'h0040);
        chk("midrst_pending_after", 16'(pending), 16'd0);
        hold(2'd0, 4);
        chk("midrst_discarded", 16'(seg), 16'h007F);

        // Randomised traffic against the model.
        cur = 2'd0;
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 35)      cur = cur + 2'd1;
            else if (r < 38) cur = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h00FF;
                2:       mask = 16'h000F;
                default: mask = 16'h0F0F;
            endcase
            step(cur, ($urandom_range(0, 6) == 0), 16'($urandom) & mask,
                 4'($urandom), ($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_frame_decoder.md
SEG_FRAME_DECODER -- requirements
Module: seg_frame_decoder

Interface
REQ-001 Parameter BLANK_LZ, default 1, 1 enables leading-zero blanking.
REQ-002 Parameter BLINK_DIV, default 24, blink phase bit index into free-running counter (BLINK_EN only).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 choice  input  2  digit select from anode driver; asynchronous to clk.
REQ-006 load  input  1  one-cycle strobe; stage data_in/dp_in.
REQ-007 data_in  input  16  four hex nibbles; [15:12] leftmost digit.
REQ-008 dp_in  input  4  decimal points; bit 3 leftmost, 1 = lit.
REQ-009 blink_mask  input  4  per-digit blink enable, bit 3 leftmost (BLINK_EN only).
REQ-010 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 dp  output  1  decimal-point cathode, active-low, registered.
REQ-012 pending  output  1  staged value awaiting frame boundary.

Function
REQ-013 The block SHALL synchronise choice through two flops before any use.
REQ-014 The block SHALL map synced choice 0/1/2/3 to nibble [15:12]/[11:8]/[7:4]/[3:0] and dp bit 3/2/1/0.
REQ-015 The block SHALL update seg/dp exactly 3 clk cycles after a choice change: 2 sync, 1 output register.
REQ-016 The block SHALL hold two 20-bit registers: stage and display, each holding 16 data + 4 dp bits.
REQ-017 The block SHALL load stage and set pending on load=1.
REQ-018 The block SHALL treat a synced choice transition 3->0 as a frame boundary.
REQ-019 At a frame boundary with pending=1, the block SHALL copy stage to display and clear pending.
REQ-020 The block SHALL let the newest load overwrite stage while pending=1; earlier staged values are lost.
REQ-021 When load coincides with a frame boundary, the block SHALL write data_in/dp_in directly into display and leave pending=0.
REQ-022 The block SHALL decode hex 0-F to standard segments: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
REQ-023 With BLANK_LZ=1, the block SHALL blank (seg=1111111) each zero nibble left of the first nonzero nibble; the choice-3 digit SHALL never be blanked.
REQ-024 A blanked digit SHALL still drive dp from its dp bit.
REQ-025 With BLANK_LZ=0, the block SHALL display all four nibbles.

Reset
REQ-026 While rst=1, the block SHALL clear stage, display, pending, the synchronisers and the blink counter.
REQ-027 While rst=1, the block SHALL drive seg=1111111 and dp=1.
REQ-028 The block SHALL discard any pending stage on rst; load during rst SHALL be ignored.
REQ-029 After rst releases, the block SHALL display 0 on the choice-3 digit and blank the others when BLANK_LZ=1.

Configuration
REQ-030 Macro SEG_FRAME_DECODER_BLINK_EN SHALL control blinking.
REQ-031 When the macro is defined, the block SHALL include a free-running 32-bit counter and the blink_mask port; digit d SHALL be blanked, seg and dp, while blink_mask[d]=1 and counter[BLINK_DIV]=1.
REQ-032 When the macro is undefined, the block SHALL omit the counter and the blink_mask port, and its behaviour SHALL equal blink_mask=0.

Structure
REQ-033 Package seg_pkg SHALL hold the segment width, the blank constant 7'b1111111, and the 16-entry hex-to-segment constants.
REQ-034 Sub-module hex_to_seg SHALL hold the combinational 4-bit to 7-bit decode and be instantiated once.
REQ-035 The synchronisers, stage/display registers, boundary detect and output register SHALL reside in the top module.

Verification
REQ-036 Scenario: after reset, load 0x1234 with dp_in=0000, cycle choice 0..3 then 0; the block SHALL show 1111001,0100100,0110000,0011001 only after the boundary, with pending 1 then 0.
REQ-037 Scenario: load 0x00A5, BLANK_LZ=1; the block SHALL blank digits 0 and 1, then show A=0001000 and 5=0010010.
REQ-038 Scenario: load 0x1111, then 0x2222 before the boundary; only 0x2222 SHALL appear, and 0x1111 SHALL never be displayed.
REQ-039 Scenario: load asserted on the same cycle as the 3->0 boundary with 0xFFFF; the block SHALL display F=0001110 on the next digit and keep pending=0.
REQ-040 Scenario: assert rst with pending=1 mid-frame; seg SHALL be 1111111 during rst, then show 0 on choice 3 with pending=0.
REQ-041 Scenario: with the BLINK_EN macro defined, BLINK_DIV=3, blink_mask=0001; digit 3 SHALL blank for 8 clocks every 16, and the other digits SHALL stay unaffected.
